// File: rtl/keccak_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : keccak_stream_feeder
// Brief    : Fetches a byte-length message as BUS_W-bit read beats, buffers
//            them in a credit-limited FIFO and streams WORD_W-bit words to the
//            Keccak core with final-partial-word / empty-last-word handling.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_stream_feeder #(
    parameter int BUS_W      = 128,
    parameter int WORD_W     = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [31:0]                     msg_len,
    output logic                            read_req,
    input  logic                            read_ack,
    output logic [31:0]                     read_addr_offset,
    input  logic [BUS_W-1:0]                ocm_data_out,
    input  logic                            bus_data_valid,
    output logic [WORD_W-1:0]               keccak_input,
    output logic                            in_ready,
    output logic                            is_last,
    output logic [$clog2(WORD_W/8)-1:0]     byte_num,
    input  logic                            buffer_full,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);

    localparam int C_BN_W       = $clog2(WORD_W/8);
    localparam int C_BEAT_SH    = $clog2(BUS_W/8);
    localparam int C_WORD_BYTES = WORD_W/8;
    localparam int C_BEAT_BYTES = BUS_W/8;
    localparam int C_WPB        = BUS_W/WORD_W;
    localparam int C_WIDX_W     = (C_WPB > 1) ? $clog2(C_WPB) : 1;
    localparam int C_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W      = C_PTR_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_TAIL   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          r_state, w_next_state;
    logic [31:0]         r_words_total, r_beats_total, r_words_sent, r_beats_req, r_addr;
    logic [C_BN_W-1:0]   r_rem;
    logic [C_CNT_W-1:0]  r_outstanding, r_count;
    logic [C_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [C_WIDX_W-1:0] r_word_idx;
    logic                r_overflow;
    logic [BUS_W-1:0]    r_mem [FIFO_DEPTH];

    logic [32:0]         w_wsum, w_bsum;
    logic [C_CNT_W:0]    w_occ;
    logic                w_start, w_word_avail, w_xfer, w_last_word, w_word_end;
    logic                w_pop, w_push, w_accept, w_full, w_ret;

    // Word/beat counts rounded up; 33-bit sums so msg_len near 2^32 cannot wrap
    assign w_wsum       = {1'b0, msg_len} + 33'(C_WORD_BYTES - 1);
    assign w_bsum       = {1'b0, msg_len} + 33'(C_BEAT_BYTES - 1);
    assign w_start      = start && (r_state == S_IDLE);
    assign w_full       = (r_count == C_CNT_W'(FIFO_DEPTH));
    assign w_word_avail = ((r_state == S_STREAM) && (r_count != '0)) || (r_state == S_TAIL);
    assign w_xfer       = w_word_avail && !buffer_full;
    assign w_last_word  = (r_words_sent == r_words_total - 32'd1);
    assign w_word_end   = (r_word_idx == C_WIDX_W'(C_WPB - 1));
    assign w_pop        = w_xfer && (r_state == S_STREAM) && (w_last_word || w_word_end);
    assign w_push       = bus_data_valid && (!w_full || w_pop);
    assign w_accept     = read_req && read_ack;
    assign w_ret        = bus_data_valid && (r_outstanding != '0);
    assign w_occ        = (C_CNT_W+1)'(r_outstanding) + (C_CNT_W+1)'(r_count);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = (msg_len == 32'd0) ? S_TAIL : S_STREAM;
            S_STREAM: if (w_xfer && w_last_word) w_next_state = (r_rem != '0) ? S_DONE : S_TAIL;
            S_TAIL:   if (w_xfer) w_next_state = S_DONE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Outputs; data lines are held at zero whenever no word is presentable
    always_comb begin
        read_req     = (r_state == S_STREAM) && (r_beats_req < r_beats_total)
                       && (w_occ < (C_CNT_W+1)'(FIFO_DEPTH));
        in_ready     = w_xfer;
        keccak_input = '0;
        is_last      = 1'b0;
        byte_num     = '0;
        if ((r_state == S_STREAM) && w_word_avail) begin
            keccak_input = r_mem[r_rd_ptr][r_word_idx*WORD_W +: WORD_W];
            if (w_last_word && (r_rem != '0)) begin
                is_last  = 1'b1;
                byte_num = r_rem;
            end
        end else if (r_state == S_TAIL) begin
            is_last = 1'b1;
        end
        busy             = (r_state != S_IDLE);
        done             = (r_state == S_DONE);
        overflow         = r_overflow;
        read_addr_offset = r_addr;
    end

    // Message counters, read-credit tracking and word position within the head beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_words_total <= '0;
            r_beats_total <= '0;
            r_rem         <= '0;
            r_words_sent  <= '0;
            r_beats_req   <= '0;
            r_addr        <= '0;
            r_outstanding <= '0;
            r_word_idx    <= '0;
        end else if (w_start) begin
            r_words_total <= 32'(w_wsum >> C_BN_W);
            r_beats_total <= 32'(w_bsum >> C_BEAT_SH);
            r_rem         <= msg_len[C_BN_W-1:0];
            r_words_sent  <= '0;
            r_beats_req   <= '0;
            r_addr        <= '0;
            r_outstanding <= '0;
            r_word_idx    <= '0;
        end else begin
            if (w_accept) begin
                r_beats_req <= r_beats_req + 32'd1;
                r_addr      <= r_addr + 32'(C_BEAT_BYTES);
            end
            if (w_accept && !w_ret)      r_outstanding <= r_outstanding + C_CNT_W'(1);
            else if (!w_accept && w_ret) r_outstanding <= r_outstanding - C_CNT_W'(1);
            if (w_xfer && (r_state == S_STREAM)) begin
                r_words_sent <= r_words_sent + 32'd1;
                r_word_idx   <= w_pop ? '0 : r_word_idx + C_WIDX_W'(1);
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + C_CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - C_CNT_W'(1);
            if (bus_data_valid && !w_push) r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= ocm_data_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_stream_feeder
// Brief    : Directed self-checking bench for keccak_stream_feeder with a
//            simple bus responder and Keccak-side transfer monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keccak_stream_feeder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  msg_len = '0;
    logic         read_req;
    logic         read_ack = 1'b0;
    logic [31:0]  read_addr_offset;
    logic [127:0] ocm_data_out = '0;
    logic         bus_data_valid = 1'b0;
    logic [63:0]  keccak_input;
    logic         in_ready, is_last, busy, done, overflow;
    logic [2:0]   byte_num;
    logic         buffer_full = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // responder / monitor controls and records
    bit   ack_rand = 0, data_en = 1, data_rand = 0, inject = 0;
    int   bf_mode = 0;
    logic [31:0] pending[$];
    logic [31:0] acc_q[$];
    logic [63:0] word_q[$];
    logic        last_q[$];
    logic [2:0]  bn_q[$];
    int   done_cnt = 0, req_cycles = 0, bf_viol = 0;

    keccak_stream_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .msg_len(msg_len),
        .read_req(read_req), .read_ack(read_ack), .read_addr_offset(read_addr_offset),
        .ocm_data_out(ocm_data_out), .bus_data_valid(bus_data_valid),
        .keccak_input(keccak_input), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full), .busy(busy),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_word(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {16'hBEEF, kk[15:0], kk * 32'h0101_0101};
    endfunction

    function automatic logic [127:0] beat_of(input logic [31:0] off);
        int b;
        b = int'(off >> 4);
        return {exp_word(2*b+1), exp_word(2*b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus responder + Keccak-side monitor: drive after the rising edge, sample on the falling edge
    initial begin
        forever begin
            @(posedge clk); #1;
            read_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            case (bf_mode)
                0:       buffer_full = 1'b0;
                1:       buffer_full = 1'b1;
                default: buffer_full = 1'($urandom_range(0, 1));
            endcase
            bus_data_valid = 1'b0;
            ocm_data_out   = '0;
            if (inject) begin
                bus_data_valid = 1'b1;
                ocm_data_out   = {4{32'hDEAD_BEEF}};
                inject         = 0;
            end else if (data_en && pending.size() > 0 && (!data_rand || $urandom_range(0, 2) == 0)) begin
                bus_data_valid = 1'b1;
                ocm_data_out   = beat_of(pending.pop_front());
            end
            @(negedge clk);
            if (read_req) req_cycles++;
            if (read_req && read_ack) begin
                acc_q.push_back(read_addr_offset);
                pending.push_back(read_addr_offset);
            end
            if (in_ready) begin
                word_q.push_back(keccak_input);
                last_q.push_back(is_last);
                bn_q.push_back(byte_num);
                if (buffer_full) bf_viol++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_records();
        acc_q.delete(); word_q.delete(); last_q.delete(); bn_q.delete();
        done_cnt = 0; req_cycles = 0; bf_viol = 0;
    endtask

    task automatic start_msg(input logic [31:0] len);
        @(posedge clk); #1;
        msg_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_xfer(input string tag, input int i, input logic [63:0] w,
                              input logic l, input logic [2:0] bn);
        check($sformatf("%s_word%0d", tag, i), (i < word_q.size()) ? word_q[i] : 64'hBAD0_BAD0_BAD0_BAD0, w);
        check($sformatf("%s_last%0d", tag, i), (i < last_q.size()) ? 64'(last_q[i]) : 64'hF, 64'(l));
        check($sformatf("%s_bn%0d", tag, i), (i < bn_q.size()) ? 64'(bn_q[i]) : 64'hF, 64'(bn));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 0);
        check({tag, "_keccak_input"}, keccak_input, 0);
        check({tag, "_is_last"}, 64'(is_last), 0);
        check({tag, "_byte_num"}, 64'(byte_num), 0);
        check({tag, "_read_req"}, 64'(read_req), 0);
        check({tag, "_read_addr"}, 64'(read_addr_offset), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_overflow"}, 64'(overflow), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 13 bytes: one beat, second word partial (5 bytes)
        clear_records();
        start_msg(32'd13);
        check("m13_busy_after_start", 64'(busy), 1);
        wait_done(100);
        check("m13_accepts", 64'(acc_q.size()), 1);
        check("m13_offset0", (acc_q.size() > 0) ? 64'(acc_q[0]) : 64'hBAD, 0);
        check("m13_xfers", 64'(word_q.size()), 2);
        check_xfer("m13", 0, exp_word(0), 1'b0, 3'd0);
        check_xfer("m13", 1, exp_word(1), 1'b1, 3'd5);
        check("m13_done_cnt", 64'(done_cnt), 1);
        check("m13_busy_end", 64'(busy), 0);

        // 16 bytes: two full words then an empty tail word
        clear_records();
        start_msg(32'd16);
        wait_done(100);
        check("m16_accepts", 64'(acc_q.size()), 1);
        check("m16_xfers", 64'(word_q.size()), 3);
        check_xfer("m16", 0, exp_word(0), 1'b0, 3'd0);
        check_xfer("m16", 1, exp_word(1), 1'b0, 3'd0);
        check_xfer("m16", 2, 64'd0, 1'b1, 3'd0);
        check("m16_done_cnt", 64'(done_cnt), 1);

        // zero-length message: tail transfer only, no reads
        clear_records();
        start_msg(32'd0);
        wait_done(100);
        check("m0_req_cycles", 64'(req_cycles), 0);
        check("m0_xfers", 64'(word_q.size()), 1);
        check_xfer("m0", 0, 64'd0, 1'b1, 3'd0);
        check("m0_done_cnt", 64'(done_cnt), 1);

        // 200 bytes with random ack/data latency and buffer_full toggling
        clear_records();
        ack_rand = 1; data_rand = 1; bf_mode = 2;
        start_msg(32'd200);
        wait_done(3000);
        ack_rand = 0; data_rand = 0; bf_mode = 0;
        check("m200_accepts", 64'(acc_q.size()), 13);
        for (int i = 0; i < 13; i++)
            check($sformatf("m200_offset%0d", i), (i < acc_q.size()) ? 64'(acc_q[i]) : 64'hBAD, 64'(16*i));
        check("m200_xfers", 64'(word_q.size()), 26);
        for (int i = 0; i < 25; i++)
            check_xfer("m200", i, exp_word(i), 1'b0, 3'd0);
        check_xfer("m200", 25, 64'd0, 1'b1, 3'd0);
        check("m200_bf_viol", 64'(bf_viol), 0);
        check("m200_done_cnt", 64'(done_cnt), 1);

        // credit limit and overflow
        clear_records();
        data_en = 0; bf_mode = 1;
        start_msg(32'd200);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("ovf_accepts_at_limit", 64'(acc_q.size()), 8);
        check("ovf_req_dropped", 64'(read_req), 0);
        data_en = 1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("ovf_not_yet", 64'(overflow), 0);
        check("ovf_req_still_low", 64'(read_req), 0);
        inject = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovf_set", 64'(overflow), 1);
        bf_mode = 0;
        wait_done(500);
        check("ovf_accepts_total", 64'(acc_q.size()), 13);
        check("ovf_xfers", 64'(word_q.size()), 26);
        check_xfer("ovf", 15, exp_word(15), 1'b0, 3'd0);
        check_xfer("ovf", 16, exp_word(16), 1'b0, 3'd0);
        check_xfer("ovf", 24, exp_word(24), 1'b0, 3'd0);
        check("ovf_sticky", 64'(overflow), 1);

        // asynchronous reset mid-STREAM, then a clean 8-byte message
        clear_records();
        start_msg(32'd200);
        repeat (6) @(posedge clk);
        #3;
        reset_n = 1'b0;
        data_en = 0;
        #1;
        check_outputs_zero("async_rst");
        pending.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pending.delete();
        clear_records();
        data_en = 1;
        start_msg(32'd8);
        wait_done(100);
        check("m8_accepts", 64'(acc_q.size()), 1);
        check("m8_offset0", (acc_q.size() > 0) ? 64'(acc_q[0]) : 64'hBAD, 0);
        check("m8_xfers", 64'(word_q.size()), 2);
        check_xfer("m8", 0, exp_word(0), 1'b0, 3'd0);
        check_xfer("m8", 1, 64'd0, 1'b1, 3'd0);
        check("m8_done_cnt", 64'(done_cnt), 1);
        check("m8_overflow", 64'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
